cordic_rotation_sequencer: RTL

Iteration controller that drives the `stageCordic` pipeline stage and collects its results. It accepts one rotation request through a valid/ready handshake: four 19-bit vertices, a 9-bit angle and a 49-bit pass-through metadata word. It issues ITERS micro-rotations through the stage, feeding each stage result back as the next operand, and presents the rotated vertices downstream through a second valid/ready handshake. It sits upstream of the stage and supplies its `nst3_*` inputs, and it consumes the stage's `new_nst3_*` outputs. The stage's sideband inputs are tied off at integration; this block carries the metadata itself.

---
 rtl/cordic_rotation_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/cordic_rotation_sequencer.sv
// Iteration controller for a CORDIC micro-rotation stage. It takes one request,
// issues ITERS micro-rotations, feeds each result back, and presents the final vertices.
module cordic_rotation_sequencer #(
  parameter int ITERS = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [151:0] req_v,
  input  logic [8:0]   req_z,
  input  logic [48:0]  req_meta,
  output logic [151:0] cs_v,
  output logic [8:0]   cs_z,
  output logic [8:0]   cs_atan,
  output logic [2:0]   cs_i,
  output logic         cs_enable_cordic,
  input  logic [151:0] cs_new_v,
  input  logic [8:0]   cs_new_z,
  input  logic         cs_out_enable_cordic,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [151:0] out_v,
  output logic [8:0]   out_z,
  output logic [48:0]  out_meta
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [2:0] LAST = 3'(ITERS - 1);

  state_t       state;
  logic [2:0]   iter;
  logic [151:0] v_reg;
  logic [8:0]   z_reg;
  logic [48:0]  meta_reg;
  logic [8:0]   atan_reg;
  logic         en_reg;
  logic         valid_reg;
  logic [151:0] neg_v;
  logic         pre_rot;

  // atan(2^-i) in units of 180/256 degrees
  function automatic logic [8:0] atan_lut(input logic [2:0] i);
    case (i)
      3'd0:    return 9'd64;
      3'd1:    return 9'd38;
      3'd2:    return 9'd20;
      3'd3:    return 9'd10;
      3'd4:    return 9'd5;
      3'd5:    return 9'd3;
      default: return 9'd1;
    endcase
  endfunction

  // Negated vertex components; the most negative value saturates instead of wrapping.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_neg
      logic [18:0] comp;
      assign comp = req_v[gi*19 +: 19];
      assign neg_v[gi*19 +: 19] = (comp == 19'h40000) ? 19'h3FFFF : 19'(-comp);
    end
  endgenerate

  // Angles outside [-128,127] are folded by a 180-degree pre-rotation.
  assign pre_rot = req_z[8] ^ req_z[7];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      iter      <= 3'd0;
      v_reg     <= '0;
      z_reg     <= '0;
      meta_reg  <= '0;
      atan_reg  <= '0;
      en_reg    <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            meta_reg <= req_meta;
            iter     <= 3'd0;
            atan_reg <= atan_lut(3'd0);
            if (req_meta[0]) begin
              v_reg     <= req_v;
              z_reg     <= req_z;
              valid_reg <= 1'b1;
              state     <= DONE;
            end else begin
              v_reg  <= pre_rot ? neg_v : req_v;
              z_reg  <= pre_rot ? (req_z ^ 9'h100) : req_z;
              en_reg <= 1'b1;
              state  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          en_reg <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          if (cs_out_enable_cordic) begin
            v_reg <= cs_new_v;
            z_reg <= cs_new_z;
            if (iter == LAST) begin
              valid_reg <= 1'b1;
              state     <= DONE;
            end else begin
              iter     <= 3'(iter + 3'd1);
              atan_reg <= atan_lut(3'(iter + 3'd1));
              en_reg   <= 1'b1;
              state    <= ISSUE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            valid_reg <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready        = (state == IDLE) && !reset;
  assign cs_v             = v_reg;
  assign cs_z             = z_reg;
  assign cs_atan          = atan_reg;
  assign cs_i             = iter;
  assign cs_enable_cordic = en_reg;
  assign out_valid        = valid_reg;
  assign out_v            = v_reg;
  assign out_z            = z_reg;
  assign out_meta         = meta_reg;

endmodule
